// File: rtl/cpu19_top.sv
// rtl/cpu19_top.sv - single-cycle 19-bit RISC core with external instruction and data memories
//
// Purpose:
//   Each cycle fetches one 19-bit instruction at PC and fully executes it
//   (decode, register read, ALU, optional load/store, write-back). Both memories
//   return read data combinationally within the same cycle.
//
// Ports:
//   clk                  in   1   rising-edge clock
//   reset_n              in   1   asynchronous reset, active HIGH despite the name
//   instr_mem_req_o      out  1   fetch request, high from the first edge after reset
//   instr_mem_addr_o     out  19  fetch address (PC, word addressed)
//   instr_mem_rd_data_i  in   19  instruction at PC, same cycle
//   data_mem_req_o       out  1   high only for a valid load/store
//   data_mem_addr_o      out  19  rs1 + sign-extended imm6
//   data_mem_byte_en_o   out  2   01 byte, 11 half/word, 00 idle
//   data_mem_wr_o        out  1   1 store, 0 load
//   data_mem_wr_data_o   out  19  store data, 0 otherwise
//   data_mem_rd_data_i   in   19  load data, same cycle

module cpu19_top (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_mem_req_o,
    output logic [18:0] instr_mem_addr_o,
    input  logic [18:0] instr_mem_rd_data_i,
    output logic        data_mem_req_o,
    output logic [18:0] data_mem_addr_o,
    output logic [1:0]  data_mem_byte_en_o,
    output logic        data_mem_wr_o,
    output logic [18:0] data_mem_wr_data_o,
    input  logic [18:0] data_mem_rd_data_i
);

    localparam logic [3:0] OP_R     = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;

    localparam logic [2:0] F7_ARITH = 3'b101;
    localparam logic [2:0] F7_LOGIC = 3'b111;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [18:0] r_pc;
    logic        r_run;          // set on the first edge after reset; gates fetch/execute
    logic [18:0] r_regs [0:7];   // entry 0 exists but is never written nor observed

    // ------------------------------------------------------------------
    // Decode. Before the first post-reset edge the instruction is forced to
    // zero (opcode 0000 = NOP), which keeps every data output quiet.
    // ------------------------------------------------------------------
    logic [18:0] w_instr;
    logic [2:0]  w_f7;
    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [2:0]  w_rd;
    logic [3:0]  w_opcode;

    assign w_instr  = r_run ? instr_mem_rd_data_i : 19'd0;
    assign w_f7     = w_instr[18:16];
    assign w_rs1    = w_instr[15:13];
    assign w_rs2    = w_instr[12:10];
    assign w_f3     = w_instr[9:7];
    assign w_rd     = w_instr[6:4];
    assign w_opcode = w_instr[3:0];

    logic [18:0] w_rs1_val;
    logic [18:0] w_rs2_val;

    assign w_rs1_val = (w_rs1 == 3'd0) ? 19'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? 19'd0 : r_regs[w_rs2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [4:0]  w_shamt;
    logic        w_shamt_big;
    logic [18:0] w_mul;
    logic [18:0] w_div;
    logic [18:0] w_sll;
    logic [18:0] w_srl;
    logic [18:0] w_sra;

    assign w_shamt     = w_rs2_val[4:0];
    // Amounts of 19..31 would leave no original bits; clamp explicitly.
    assign w_shamt_big = (w_shamt >= 5'd19);
    assign w_mul       = w_rs1_val * w_rs2_val;
    assign w_div       = (w_rs2_val == 19'd0) ? 19'h7FFFF : (w_rs1_val / w_rs2_val);
    assign w_sll       = w_shamt_big ? 19'd0 : (w_rs1_val << w_shamt);
    assign w_srl       = w_shamt_big ? 19'd0 : (w_rs1_val >> w_shamt);
    assign w_sra       = w_shamt_big ? {19{w_rs1_val[18]}}
                                     : 19'($signed(w_rs1_val) >>> w_shamt);

    logic        w_alu_valid;
    logic [18:0] w_alu_res;

    always_comb begin
        w_alu_valid = 1'b0;
        w_alu_res   = 19'd0;
        if (w_opcode == OP_R) begin
            if (w_f7 == F7_ARITH) begin
                w_alu_valid = 1'b1;
                case (w_f3)
                    3'b000:  w_alu_res = w_rs1_val + w_rs2_val;
                    3'b001:  w_alu_res = w_rs1_val - w_rs2_val;
                    3'b010:  w_alu_res = w_mul;
                    3'b011:  w_alu_res = w_div;
                    3'b100:  w_alu_res = w_rs1_val + 19'd1;
                    3'b101:  w_alu_res = w_rs1_val - 19'd1;
                    3'b110:  w_alu_res = w_rs1_val | w_rs2_val;
                    default: w_alu_res = w_rs1_val & w_rs2_val;
                endcase
            end else if (w_f7 == F7_LOGIC) begin
                w_alu_valid = 1'b1;
                case (w_f3)
                    3'b000:  w_alu_res = w_rs1_val ^ w_rs2_val;
                    3'b001:  w_alu_res = ~w_rs1_val;
                    3'b010:  w_alu_res = ($signed(w_rs1_val) < $signed(w_rs2_val)) ? 19'd1 : 19'd0;
                    3'b100:  w_alu_res = w_sll;
                    3'b101:  w_alu_res = w_srl;
                    3'b110:  w_alu_res = w_sra;
                    default: w_alu_valid = 1'b0;   // 011 and 111 are unassigned
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Load / store decode. The two formats place the low immediate bits
    // in different fields: loads use the rs2 slot, stores use the rd slot.
    // ------------------------------------------------------------------
    logic        w_ld_valid;
    logic        w_st_valid;
    logic        w_byte_access;
    logic [18:0] w_ld_imm;
    logic [18:0] w_st_imm;
    logic [18:0] w_ld_addr;
    logic [18:0] w_st_addr;
    logic [18:0] w_ld_data;
    logic [18:0] w_st_data;

    assign w_ld_imm  = {{13{w_instr[18]}}, w_instr[18:16], w_instr[12:10]};
    assign w_st_imm  = {{13{w_instr[18]}}, w_instr[18:16], w_instr[6:4]};
    assign w_ld_addr = w_rs1_val + w_ld_imm;
    assign w_st_addr = w_rs1_val + w_st_imm;

    always_comb begin
        w_ld_valid    = 1'b0;
        w_st_valid    = 1'b0;
        w_byte_access = 1'b0;
        w_ld_data     = 19'd0;
        w_st_data     = 19'd0;
        if (w_opcode == OP_LOAD) begin
            case (w_f3)
                3'b001: begin
                    w_ld_valid    = 1'b1;
                    w_byte_access = 1'b1;
                    w_ld_data     = {{11{data_mem_rd_data_i[7]}}, data_mem_rd_data_i[7:0]};
                end
                3'b010: begin
                    w_ld_valid    = 1'b1;
                    w_byte_access = 1'b1;
                    w_ld_data     = {11'd0, data_mem_rd_data_i[7:0]};
                end
                3'b011: begin
                    w_ld_valid = 1'b1;
                    w_ld_data  = {{3{data_mem_rd_data_i[15]}}, data_mem_rd_data_i[15:0]};
                end
                3'b100: begin
                    w_ld_valid = 1'b1;
                    w_ld_data  = data_mem_rd_data_i;
                end
                default: w_ld_valid = 1'b0;
            endcase
        end else if (w_opcode == OP_STORE) begin
            case (w_f3)
                3'b001: begin
                    w_st_valid    = 1'b1;
                    w_byte_access = 1'b1;
                    w_st_data     = {11'd0, w_rs2_val[7:0]};
                end
                3'b011: begin
                    w_st_valid = 1'b1;
                    w_st_data  = {3'd0, w_rs2_val[15:0]};
                end
                3'b100: begin
                    w_st_valid = 1'b1;
                    w_st_data  = w_rs2_val;
                end
                default: w_st_valid = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data memory port (combinational from the current instruction)
    // ------------------------------------------------------------------
    always_comb begin
        data_mem_req_o     = 1'b0;
        data_mem_addr_o    = 19'd0;
        data_mem_byte_en_o = 2'b00;
        data_mem_wr_o      = 1'b0;
        data_mem_wr_data_o = 19'd0;
        if (w_ld_valid) begin
            data_mem_req_o     = 1'b1;
            data_mem_addr_o    = w_ld_addr;
            data_mem_byte_en_o = w_byte_access ? 2'b01 : 2'b11;
        end else if (w_st_valid) begin
            data_mem_req_o     = 1'b1;
            data_mem_addr_o    = w_st_addr;
            data_mem_byte_en_o = w_byte_access ? 2'b01 : 2'b11;
            data_mem_wr_o      = 1'b1;
            data_mem_wr_data_o = w_st_data;
        end
    end

    assign instr_mem_req_o  = r_run;
    assign instr_mem_addr_o = r_pc;

    // ------------------------------------------------------------------
    // Write-back and PC
    // ------------------------------------------------------------------
    logic        w_wb_en;
    logic [18:0] w_wb_data;

    assign w_wb_en   = (w_alu_valid || w_ld_valid) && (w_rd != 3'd0);
    assign w_wb_data = w_ld_valid ? w_ld_data : w_alu_res;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_pc  <= 19'd0;
            r_run <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 19'd0;
            end
        end else if (!r_run) begin
            // First edge out of reset only starts fetching; PC stays at 0.
            r_run <= 1'b1;
        end else begin
            r_pc <= r_pc + 19'd1;   // wraps naturally at 19 bits
            if (w_wb_en) begin
                r_regs[w_rd] <= w_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu19_top.sv
// tb/tb_cpu19_top.sv - table-driven directed bench for cpu19_top

module tb_cpu19_top;

    logic        clk;
    logic        reset_n;
    logic        instr_mem_req_o;
    logic [18:0] instr_mem_addr_o;
    logic [18:0] instr_mem_rd_data_i;
    logic        data_mem_req_o;
    logic [18:0] data_mem_addr_o;
    logic [1:0]  data_mem_byte_en_o;
    logic        data_mem_wr_o;
    logic [18:0] data_mem_wr_data_o;
    logic [18:0] data_mem_rd_data_i;

    cpu19_top dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .instr_mem_req_o     (instr_mem_req_o),
        .instr_mem_addr_o    (instr_mem_addr_o),
        .instr_mem_rd_data_i (instr_mem_rd_data_i),
        .data_mem_req_o      (data_mem_req_o),
        .data_mem_addr_o     (data_mem_addr_o),
        .data_mem_byte_en_o  (data_mem_byte_en_o),
        .data_mem_wr_o       (data_mem_wr_o),
        .data_mem_wr_data_o  (data_mem_wr_data_o),
        .data_mem_rd_data_i  (data_mem_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4, R5 = 3'd5, R6 = 3'd6, R7 = 3'd7;
    localparam logic [2:0] FA = 3'b101, FB = 3'b111;

    typedef struct {
        string       name;
        logic [18:0] instr;
        logic [18:0] rdata;
        logic        req;
        logic [18:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic [18:0] wdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_pc   = 0;

    function automatic logic [18:0] enc_r(logic [2:0] f7, logic [2:0] rs1, logic [2:0] rs2,
                                          logic [2:0] f3, logic [2:0] rd);
        return {f7, rs1, rs2, f3, rd, 4'b0001};
    endfunction

    function automatic logic [18:0] enc_ld(logic [5:0] imm, logic [2:0] rs1, logic [2:0] f3,
                                           logic [2:0] rd);
        return {imm[5:3], rs1, imm[2:0], f3, rd, 4'b0110};
    endfunction

    function automatic logic [18:0] enc_st(logic [5:0] imm, logic [2:0] rs1, logic [2:0] rs2,
                                           logic [2:0] f3);
        return {imm[5:3], rs1, rs2, f3, imm[2:0], 4'b0111};
    endfunction

    function automatic vec_t mk(string nm, logic [18:0] ins, logic [18:0] rd, logic rq,
                                logic [18:0] ad, logic [1:0] be, logic wr, logic [18:0] wd);
        vec_t v;
        v.name = nm; v.instr = ins; v.rdata = rd; v.req = rq;
        v.addr = ad; v.be = be; v.wr = wr; v.wdata = wd;
        return v;
    endfunction

    // Instruction with no data-port activity expected.
    function automatic vec_t quiet(string nm, logic [18:0] ins);
        return mk(nm, ins, 19'd0, 1'b0, 19'd0, 2'b00, 1'b0, 19'd0);
    endfunction

    // Word store of a register to address 0: exposes the register value.
    function automatic vec_t show(string nm, logic [2:0] rs, logic [18:0] val);
        return mk(nm, enc_st(6'd0, R0, rs, 3'b100), 19'd0, 1'b1, 19'd0, 2'b11, 1'b1, val);
    endfunction

    task automatic chk(string nm, logic [18:0] act, logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    task automatic chk_port(string nm, logic [18:0] pc, logic irq, logic rq,
                            logic [18:0] ad, logic [1:0] be, logic wr, logic [18:0] wd);
        chk({nm, ".pc"},    instr_mem_addr_o, pc);
        chk({nm, ".ireq"},  19'(instr_mem_req_o), 19'(irq));
        chk({nm, ".dreq"},  19'(data_mem_req_o), 19'(rq));
        chk({nm, ".daddr"}, data_mem_addr_o, ad);
        chk({nm, ".be"},    19'(data_mem_byte_en_o), 19'(be));
        chk({nm, ".wr"},    19'(data_mem_wr_o), 19'(wr));
        chk({nm, ".wdata"}, data_mem_wr_data_o, wd);
    endtask

    // One cycle: drive after the rising edge, compare on the falling edge.
    task automatic run_vec(vec_t v);
        @(posedge clk);
        #1;
        instr_mem_rd_data_i = v.instr;
        data_mem_rd_data_i  = v.rdata;
        @(negedge clk);
        chk_port(v.name, 19'(exp_pc), 1'b1, v.req, v.addr, v.be, v.wr, v.wdata);
        exp_pc++;
    endtask

    initial begin
        // register values tracked by hand in the trailing comments
        vecs.push_back(mk("lw_r2",  enc_ld(6'd0,  R0, 3'b100, R2), 19'h12345, 1, 19'h00000, 2'b11, 0, 0)); // r2=12345
        vecs.push_back(mk("lw_r3",  enc_ld(6'h3F, R2, 3'b100, R3), 19'h00003, 1, 19'h12344, 2'b11, 0, 0)); // r3=3
        vecs.push_back(quiet("add", enc_r(FA, R2, R3, 3'b000, R2)));                                      // r2=12348
        vecs.push_back(show("s_add", R2, 19'h12348));
        vecs.push_back(quiet("sub", enc_r(FA, R2, R3, 3'b001, R2)));                                      // r2=12345
        vecs.push_back(mk("sw_a5",  enc_st(6'd5,  R0, R3, 3'b100), 0, 1, 19'h00005, 2'b11, 1, 19'h00003));
        vecs.push_back(quiet("mul", enc_r(FA, R2, R3, 3'b010, R4)));                                      // r4=369CF
        vecs.push_back(mk("sw_neg", enc_st(6'h3E, R0, R4, 3'b100), 0, 1, 19'h7FFFE, 2'b11, 1, 19'h369CF));
        vecs.push_back(quiet("div0", enc_r(FA, R2, R0, 3'b011, R5)));                                     // r5=7FFFF
        vecs.push_back(show("s_div0", R5, 19'h7FFFF));
        vecs.push_back(quiet("div", enc_r(FA, R4, R3, 3'b011, R5)));                                      // r5=12345
        vecs.push_back(mk("sh",     enc_st(6'd1,  R2, R5, 3'b011), 0, 1, 19'h12346, 2'b11, 1, 19'h02345));
        vecs.push_back(mk("lb",     enc_ld(6'd0,  R0, 3'b001, R6), 19'h00080, 1, 0, 2'b01, 0, 0));         // r6=7FF80
        vecs.push_back(show("s_lb", R6, 19'h7FF80));
        vecs.push_back(mk("lbu",    enc_ld(6'd0,  R0, 3'b010, R6), 19'h5A380, 1, 0, 2'b01, 0, 0));         // r6=00080
        vecs.push_back(show("s_lbu", R6, 19'h00080));
        vecs.push_back(mk("lh",     enc_ld(6'd0,  R0, 3'b011, R7), 19'h48765, 1, 0, 2'b11, 0, 0));         // r7=78765
        vecs.push_back(show("s_lh", R7, 19'h78765));
        vecs.push_back(mk("sb",     enc_st(6'd0,  R0, R2, 3'b001), 0, 1, 0, 2'b01, 1, 19'h00045));
        vecs.push_back(mk("lw_r1a", enc_ld(6'd0,  R0, 3'b100, R1), 19'h00014, 1, 0, 2'b11, 0, 0));         // r1=20
        vecs.push_back(quiet("sll20", enc_r(FB, R3, R1, 3'b100, R6)));                                    // r6=0
        vecs.push_back(show("s_sll20", R6, 19'h00000));
        vecs.push_back(mk("lw_r1b", enc_ld(6'd0,  R0, 3'b100, R1), 19'h00001, 1, 0, 2'b11, 0, 0));         // r1=1
        vecs.push_back(mk("lw_r7",  enc_ld(6'd0,  R0, 3'b100, R7), 19'h40000, 1, 0, 2'b11, 0, 0));         // r7=40000
        vecs.push_back(quiet("sra1", enc_r(FB, R7, R1, 3'b110, R7)));                                     // r7=60000
        vecs.push_back(show("s_sra1", R7, 19'h60000));
        vecs.push_back(quiet("srl1", enc_r(FB, R7, R1, 3'b101, R6)));                                     // r6=30000
        vecs.push_back(show("s_srl1", R6, 19'h30000));
        vecs.push_back(quiet("slt_t", enc_r(FB, R7, R3, 3'b010, R5)));                                    // r5=1
        vecs.push_back(show("s_slt_t", R5, 19'h00001));
        vecs.push_back(quiet("slt_f", enc_r(FB, R3, R7, 3'b010, R5)));                                    // r5=0
        vecs.push_back(show("s_slt_f", R5, 19'h00000));
        vecs.push_back(quiet("xor", enc_r(FB, R2, R3, 3'b000, R5)));
        vecs.push_back(show("s_xor", R5, 19'h12346));
        vecs.push_back(quiet("not", enc_r(FB, R2, R0, 3'b001, R5)));
        vecs.push_back(show("s_not", R5, 19'h6DCBA));
        vecs.push_back(quiet("or",  enc_r(FA, R2, R7, 3'b110, R5)));
        vecs.push_back(show("s_or", R5, 19'h72345));
        vecs.push_back(quiet("and", enc_r(FA, R2, R4, 3'b111, R5)));
        vecs.push_back(show("s_and", R5, 19'h12145));
        vecs.push_back(quiet("inc", enc_r(FA, R7, R0, 3'b100, R5)));
        vecs.push_back(show("s_inc", R5, 19'h60001));
        vecs.push_back(quiet("dec0", enc_r(FA, R0, R0, 3'b101, R5)));
        vecs.push_back(show("s_dec0", R5, 19'h7FFFF));
        vecs.push_back(quiet("wr_r0", enc_r(FA, R2, R3, 3'b000, R0)));
        vecs.push_back(show("s_r0", R0, 19'h00000));
        vecs.push_back(quiet("op1111", 19'h7FFFF));
        vecs.push_back(quiet("ld_f3_0", enc_ld(6'd0, R0, 3'b000, R7)));
        vecs.push_back(quiet("ld_f3_5", enc_ld(6'd0, R0, 3'b101, R7)));
        vecs.push_back(quiet("st_f3_2", enc_st(6'd0, R0, R2, 3'b010)));
        vecs.push_back(quiet("rb_f3_3", enc_r(FB, R2, R3, 3'b011, R7)));
        vecs.push_back(quiet("f7_000",  enc_r(3'b000, R2, R3, 3'b000, R7)));
        vecs.push_back(show("s_nop_r7", R7, 19'h60000));
        vecs.push_back(mk("lw_r1c", enc_ld(6'd0,  R0, 3'b100, R1), 19'h00013, 1, 0, 2'b11, 0, 0));         // r1=19
        vecs.push_back(quiet("sra19", enc_r(FB, R7, R1, 3'b110, R6)));
        vecs.push_back(show("s_sra19", R6, 19'h7FFFF));
        vecs.push_back(quiet("srl19", enc_r(FB, R7, R1, 3'b101, R6)));
        vecs.push_back(show("s_srl19", R6, 19'h00000));

        // Reset state: a load is presented, but nothing may leave the core.
        reset_n             = 1'b1;
        instr_mem_rd_data_i = enc_ld(6'd3, R0, 3'b100, R2);
        data_mem_rd_data_i  = 19'h7FFFF;
        repeat (2) @(negedge clk);
        chk_port("rst", 19'd0, 1'b0, 1'b0, 19'd0, 2'b00, 1'b0, 19'd0);

        // Release: still idle until the next rising edge.
        reset_n = 1'b0;
        #1;
        chk_port("rel", 19'd0, 1'b0, 1'b0, 19'd0, 2'b00, 1'b0, 19'd0);

        exp_pc = 0;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Mid-run asynchronous reset: outputs drop without a clock edge.
        @(posedge clk);
        #1;
        instr_mem_rd_data_i = enc_st(6'd0, R0, R7, 3'b100);
        @(negedge clk);
        chk_port("pre_rst", 19'(exp_pc), 1'b1, 1'b1, 19'd0, 2'b11, 1'b1, 19'h60000);
        #2;
        reset_n = 1'b1;
        #1;
        chk_port("async_rst", 19'd0, 1'b0, 1'b0, 19'd0, 2'b00, 1'b0, 19'd0);
        @(negedge clk);
        reset_n = 1'b0;

        // Registers were cleared by the reset; PC restarts from 0.
        exp_pc = 0;
        run_vec(show("post_r7", R7, 19'h00000));
        run_vec(show("post_r2", R2, 19'h00000));
        run_vec(quiet("post_nop", enc_r(FA, R0, R0, 3'b100, R1)));
        run_vec(show("post_inc", R1, 19'h00001));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
